// File: rtl/t01_ai_move_scheduler.sv
// AI placement search sequencer: walks every (column, rotation) candidate, requests a feature
// extraction for each, scores the result and keeps the best one as the move plan.
// Optional build macro: T01_AI_SCHED_ROT_PRUNE_EN limits the rotations searched to num_rot_i.
module t01_ai_move_scheduler #(
    parameter int unsigned NUM_COLS   = 10,
    parameter int unsigned NUM_ROT    = 4,
    parameter int unsigned FE_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ai_en_i,
    input  logic       spawn_i,
    input  logic [4:0] block_type_i,
    input  logic [2:0] num_rot_i,
    output logic       extract_start_o,
    output logic [3:0] cand_col_o,
    output logic [1:0] cand_rot_o,
    input  logic       extract_ready_i,
    input  logic [7:0] lines_cleared_i,
    input  logic [7:0] holes_i,
    input  logic [7:0] bumpiness_i,
    input  logic [7:0] height_sum_i,
    output logic [3:0] best_col_o,
    output logic [1:0] best_rot_o,
    output logic [4:0] best_type_o,
    output logic       plan_valid_o,
    output logic       busy_o,
    output logic       timeout_o
);

    localparam int unsigned     CntW        = $clog2(FE_TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(FE_TIMEOUT - 1);
    localparam logic [3:0]      LastCol     = 4'(NUM_COLS - 1);
    // Lowest 13-bit value; any real score beats it.
    localparam logic signed [12:0] ScoreMin = 13'sh1000;

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StScore, StNext, StDone} state_e;

    state_e state_q, state_d;

    logic [3:0]         cand_col_q, cand_col_d;
    logic [1:0]         cand_rot_q, cand_rot_d;
    logic [3:0]         best_col_q, best_col_d;
    logic [1:0]         best_rot_q, best_rot_d;
    logic [4:0]         best_type_q, best_type_d;
    logic signed [12:0] best_score_q, best_score_d;
    logic               timeout_q, timeout_d;
    logic [CntW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [7:0]         lines_q, lines_d;
    logic [7:0]         holes_q, holes_d;
    logic [7:0]         bump_q, bump_d;
    logic [7:0]         height_q, height_d;

    logic               start_search;
    logic               wait_expired;
    logic               last_cand;
    logic [2:0]         rot_limit;
    logic signed [12:0] score;

    // A spawn while AI mode is active always (re)starts the search, even mid-search.
    assign start_search = spawn_i && ai_en_i;
    assign wait_expired = (wait_cnt_q == TimeoutLast);

`ifdef T01_AI_SCHED_ROT_PRUNE_EN
    logic [2:0] rot_limit_q, rot_limit_d;
    logic [2:0] num_rot_clamped;

    // Clamp the requested rotation count into 1..NUM_ROT.
    always_comb begin
        if (num_rot_i == 3'd0) begin
            num_rot_clamped = 3'd1;
        end else if (num_rot_i > 3'(NUM_ROT)) begin
            num_rot_clamped = 3'(NUM_ROT);
        end else begin
            num_rot_clamped = num_rot_i;
        end
    end

    // Capture the rotation limit of the piece being searched.
    always_comb begin
        rot_limit_d = start_search ? num_rot_clamped : rot_limit_q;
    end

    // Rotation limit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_limit_q <= 3'(NUM_ROT);
        end else begin
            rot_limit_q <= rot_limit_d;
        end
    end

    assign rot_limit = rot_limit_q;
`else
    logic unused_num_rot;

    assign unused_num_rot = ^num_rot_i;
    assign rot_limit      = 3'(NUM_ROT);
`endif

    assign last_cand = (cand_col_q == LastCol) && ({1'b0, cand_rot_q} == rot_limit - 3'd1);

    // score = 8*lines - 4*holes - bumpiness - height_sum, zero-extended into 13 bits.
    assign score = $signed({2'b00, lines_q, 3'b000}) - $signed({3'b000, holes_q, 2'b00})
                 - $signed({5'b00000, bump_q}) - $signed({5'b00000, height_q});

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: AI disable dominates, then spawn, then the normal walk.
    always_comb begin
        state_d = state_q;
        if (!ai_en_i) begin
            state_d = StIdle;
        end else if (spawn_i) begin
            state_d = StIssue;
        end else begin
            case (state_q)
                StIdle:  state_d = StIdle;
                StIssue: state_d = StWait;
                StWait: begin
                    if (extract_ready_i) begin
                        state_d = StScore;
                    end else if (wait_expired) begin
                        state_d = StNext;
                    end
                end
                StScore: state_d = StNext;
                StNext:  state_d = last_cand ? StDone : StIssue;
                StDone:  state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs, decoded from the current state only.
    always_comb begin
        extract_start_o = (state_q == StIssue);
        plan_valid_o    = (state_q == StDone);
        busy_o          = (state_q != StIdle) && (state_q != StDone);
    end

    // Datapath next state: candidate walk, wait counter, feature capture and best tracking.
    always_comb begin
        cand_col_d   = cand_col_q;
        cand_rot_d   = cand_rot_q;
        best_col_d   = best_col_q;
        best_rot_d   = best_rot_q;
        best_type_d  = best_type_q;
        best_score_d = best_score_q;
        timeout_d    = timeout_q;
        wait_cnt_d   = wait_cnt_q;
        lines_d      = lines_q;
        holes_d      = holes_q;
        bump_d       = bump_q;
        height_d     = height_q;
        if (start_search) begin
            best_type_d  = block_type_i;
            cand_col_d   = '0;
            cand_rot_d   = '0;
            best_col_d   = '0;
            best_rot_d   = '0;
            best_score_d = ScoreMin;
            timeout_d    = 1'b0;
        end else if (ai_en_i) begin
            case (state_q)
                StIssue: wait_cnt_d = '0;
                StWait: begin
                    if (extract_ready_i) begin
                        lines_d  = lines_cleared_i;
                        holes_d  = holes_i;
                        bump_d   = bumpiness_i;
                        height_d = height_sum_i;
                    end else if (wait_expired) begin
                        timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                StScore: begin
                    // Strict compare keeps the earliest candidate on ties.
                    if (score > best_score_q) begin
                        best_score_d = score;
                        best_col_d   = cand_col_q;
                        best_rot_d   = cand_rot_q;
                    end
                end
                StNext: begin
                    if (!last_cand) begin
                        if (cand_col_q == LastCol) begin
                            cand_col_d = '0;
                            cand_rot_d = cand_rot_q + 2'd1;
                        end else begin
                            cand_col_d = cand_col_q + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_col_q   <= '0;
            cand_rot_q   <= '0;
            best_col_q   <= '0;
            best_rot_q   <= '0;
            best_type_q  <= '0;
            best_score_q <= ScoreMin;
            timeout_q    <= 1'b0;
            wait_cnt_q   <= '0;
            lines_q      <= '0;
            holes_q      <= '0;
            bump_q       <= '0;
            height_q     <= '0;
        end else begin
            cand_col_q   <= cand_col_d;
            cand_rot_q   <= cand_rot_d;
            best_col_q   <= best_col_d;
            best_rot_q   <= best_rot_d;
            best_type_q  <= best_type_d;
            best_score_q <= best_score_d;
            timeout_q    <= timeout_d;
            wait_cnt_q   <= wait_cnt_d;
            lines_q      <= lines_d;
            holes_q      <= holes_d;
            bump_q       <= bump_d;
            height_q     <= height_d;
        end
    end

    assign cand_col_o  = cand_col_q;
    assign cand_rot_o  = cand_rot_q;
    assign best_col_o  = best_col_q;
    assign best_rot_o  = best_rot_q;
    assign best_type_o = best_type_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_t01_ai_move_scheduler.sv
// Self-checking bench for t01_ai_move_scheduler: a behavioural extractor answers each request
// from per-candidate feature tables; a whole-search argmax model predicts the plan.
module tb_t01_ai_move_scheduler;

    localparam int NumCols = 10;
    localparam int NumRot  = 4;
    localparam int NumCand = NumCols * NumRot;

    logic       clk;
    logic       rst_n;
    logic       ai_en_i;
    logic       spawn_i;
    logic [4:0] block_type_i;
    logic [2:0] num_rot_i;
    logic       extract_start_o;
    logic [3:0] cand_col_o;
    logic [1:0] cand_rot_o;
    logic       extract_ready_i;
    logic [7:0] lines_cleared_i;
    logic [7:0] holes_i;
    logic [7:0] bumpiness_i;
    logic [7:0] height_sum_i;
    logic [3:0] best_col_o;
    logic [1:0] best_rot_o;
    logic [4:0] best_type_o;
    logic       plan_valid_o;
    logic       busy_o;
    logic       timeout_o;

    int n_checks;
    int n_errors;
    int pulses_total;

    // Extractor behaviour: features per candidate index rot*NumCols+col, and no-answer flags.
    int f_lines[NumCand];
    int f_holes[NumCand];
    int f_bump[NumCand];
    int f_height[NumCand];
    bit f_drop[NumCand];
    int lat;

    typedef struct {
        logic [4:0] typ;
        logic [2:0] nr;
        int         pat;
        int         lat;
        int         exp_col;
        int         exp_rot;
    } vec_t;

    vec_t vecs[6];

    t01_ai_move_scheduler #(
        .NUM_COLS  (NumCols),
        .NUM_ROT   (NumRot),
        .FE_TIMEOUT(1023)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ai_en_i        (ai_en_i),
        .spawn_i        (spawn_i),
        .block_type_i   (block_type_i),
        .num_rot_i      (num_rot_i),
        .extract_start_o(extract_start_o),
        .cand_col_o     (cand_col_o),
        .cand_rot_o     (cand_rot_o),
        .extract_ready_i(extract_ready_i),
        .lines_cleared_i(lines_cleared_i),
        .holes_i        (holes_i),
        .bumpiness_i    (bumpiness_i),
        .height_sum_i   (height_sum_i),
        .best_col_o     (best_col_o),
        .best_rot_o     (best_rot_o),
        .best_type_o    (best_type_o),
        .plan_valid_o   (plan_valid_o),
        .busy_o         (busy_o),
        .timeout_o      (timeout_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count extraction requests.
    initial begin
        pulses_total = 0;
        forever begin
            @(negedge clk);
            if (extract_start_o === 1'b1) pulses_total++;
        end
    end

    // Extractor model: answer each request lat cycles later unless the candidate is dropped.
    initial begin
        int k;
        extract_ready_i = 1'b0;
        lines_cleared_i = '0;
        holes_i         = '0;
        bumpiness_i     = '0;
        height_sum_i    = '0;
        forever begin
            @(negedge clk);
            if (extract_start_o === 1'b1 && rst_n === 1'b1) begin
                k = int'(cand_rot_o) * NumCols + int'(cand_col_o);
                if (k < NumCand && !f_drop[k]) begin
                    repeat (lat) @(negedge clk);
                    extract_ready_i = 1'b1;
                    lines_cleared_i = 8'(f_lines[k]);
                    holes_i         = 8'(f_holes[k]);
                    bumpiness_i     = 8'(f_bump[k]);
                    height_sum_i    = 8'(f_height[k]);
                    @(negedge clk);
                    extract_ready_i = 1'b0;
                    lines_cleared_i = '0;
                    holes_i         = '0;
                    bumpiness_i     = '0;
                    height_sum_i    = '0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int rot_lim(input int nr);
`ifdef T01_AI_SCHED_ROT_PRUNE_EN
        if (nr == 0) return 1;
        if (nr > NumRot) return NumRot;
        return nr;
`else
        if (nr < 0) return 0;
        return NumRot;
`endif
    endfunction

    // Reference: visit candidates rotation-major, keep first strict maximum of the score.
    function automatic void model(input int nr, output int ecol, output int erot,
                                  output int epulses, output int eto);
        int best;
        int s;
        int rl;
        rl   = rot_lim(nr);
        best = -4096;
        ecol = 0;
        erot = 0;
        eto  = 0;
        for (int r = 0; r < rl; r++) begin
            for (int c = 0; c < NumCols; c++) begin
                int k;
                k = r * NumCols + c;
                if (f_drop[k]) begin
                    eto = 1;
                end else begin
                    s = 8 * f_lines[k] - 4 * f_holes[k] - f_bump[k] - f_height[k];
                    if (s > best) begin
                        best = s;
                        ecol = c;
                        erot = r;
                    end
                end
            end
        end
        epulses = rl * NumCols;
    endfunction

    // 0: all zero. 1: holes=1 except (6,2) scoring 11. 2: holes=1 except (3,0),(7,1) scoring 5.
    // 3: random. 4: holes=1 with (0,0) never answered.
    task automatic fill_pattern(input int p);
        for (int k = 0; k < NumCand; k++) begin
            f_drop[k]   = 1'b0;
            f_lines[k]  = 0;
            f_holes[k]  = (p == 1 || p == 2 || p == 4) ? 1 : 0;
            f_bump[k]   = 0;
            f_height[k] = 0;
            if (p == 3) begin
                f_lines[k]  = int'($urandom_range(0, 255));
                f_holes[k]  = int'($urandom_range(0, 255));
                f_bump[k]   = int'($urandom_range(0, 255));
                f_height[k] = int'($urandom_range(0, 255));
            end
        end
        if (p == 1) begin
            f_lines[26] = 2; f_holes[26] = 0; f_bump[26] = 1; f_height[26] = 4;
        end
        if (p == 2) begin
            f_lines[3]  = 1; f_holes[3]  = 0; f_bump[3]  = 1; f_height[3]  = 2;
            f_lines[17] = 1; f_holes[17] = 0; f_bump[17] = 1; f_height[17] = 2;
        end
        if (p == 4) f_drop[0] = 1'b1;
    endtask

    task automatic do_spawn(input logic [4:0] typ, input logic [2:0] nr, output int base);
        @(negedge clk);
        spawn_i      = 1'b1;
        block_type_i = typ;
        num_rot_i    = nr;
        #1 base = pulses_total;
        @(negedge clk);
        spawn_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, input int base,
                             output int npulses);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (plan_valid_o === 1'b1) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1 npulses = pulses_total - base;
        check({name, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic check_plan(input string name, input logic [4:0] typ, input int nr,
                              input int npulses, input int ecol, input int erot);
        int mcol, mrot, mpulses, mto;
        model(nr, mcol, mrot, mpulses, mto);
        check({name, "_pulses"}, 32'(npulses), 32'(mpulses));
        check({name, "_col"}, 32'(best_col_o), 32'(ecol));
        check({name, "_rot"}, 32'(best_rot_o), 32'(erot));
        check({name, "_type"}, 32'(best_type_o), 32'(typ));
        check({name, "_busy"}, 32'(busy_o), 32'd0);
        check({name, "_timeout"}, 32'(timeout_o), 32'(mto));
    endtask

    initial begin
        int base, np, mcol, mrot, mpulses, mto;
        logic [4:0] rt;
        logic [2:0] rn;
        n_checks = 0;
        n_errors = 0;
        lat = 2;
        fill_pattern(0);
        rst_n        = 1'b0;
        ai_en_i      = 1'b0;
        spawn_i      = 1'b0;
        block_type_i = '0;
        num_rot_i    = '0;

        vecs[0] = '{5'd5,  3'd4, 0, 2, 0, 0};
        vecs[1] = '{5'd9,  3'd4, 1, 2, 6, 2};
        vecs[2] = '{5'd17, 3'd4, 2, 1, 3, 0};
        vecs[3] = '{5'd5,  3'd1, 0, 2, 0, 0};
        vecs[4] = '{5'd3,  3'd0, 0, 1, 0, 0};
        vecs[5] = '{5'd31, 3'd7, 1, 3, 6, 2};

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_best_col", 32'(best_col_o), 32'd0);
        check("rst_best_rot", 32'(best_rot_o), 32'd0);
        check("rst_best_type", 32'(best_type_o), 32'd0);
        check("rst_plan_valid", 32'(plan_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        check("rst_extract_start", 32'(extract_start_o), 32'd0);
        check("rst_cand", 32'({cand_col_o, cand_rot_o}), 32'd0);
        rst_n   = 1'b1;
        ai_en_i = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven searches.
        for (int i = 0; i < 6; i++) begin
            fill_pattern(vecs[i].pat);
            lat = vecs[i].lat;
            do_spawn(vecs[i].typ, vecs[i].nr, base);
            check($sformatf("v%0d_busy_run", i), 32'(busy_o), 32'd1);
            wait_done($sformatf("v%0d", i), 3000, base, np);
            check($sformatf("v%0d_plan", i), 32'(plan_valid_o), 32'd1);
            check_plan($sformatf("v%0d", i), vecs[i].typ, int'(vecs[i].nr), np,
                       vecs[i].exp_col, vecs[i].exp_rot);
        end

        // Randomized searches against the model.
        for (int i = 0; i < 5; i++) begin
            fill_pattern(3);
            lat = int'($urandom_range(1, 4));
            rt  = 5'($urandom);
            rn  = 3'($urandom_range(0, 7));
            model(int'(rn), mcol, mrot, mpulses, mto);
            do_spawn(rt, rn, base);
            wait_done($sformatf("rnd%0d", i), 3000, base, np);
            check_plan($sformatf("rnd%0d", i), rt, int'(rn), np, mcol, mrot);
        end

        // Candidate (0,0) never answered: timeout after FE_TIMEOUT wait cycles, search goes on.
        fill_pattern(4);
        lat = 2;
        do_spawn(5'd12, 3'd4, base);
        repeat (998) @(negedge clk);
        #1;
        check("to_early_flag", 32'(timeout_o), 32'd0);
        check("to_early_pulses", 32'(pulses_total - base), 32'd1);
        repeat (30) @(negedge clk);
        #1;
        check("to_flag", 32'(timeout_o), 32'd1);
        check("to_next_pulses", 32'(pulses_total - base), 32'd2);
        wait_done("to", 3000, base, np);
        check_plan("to", 5'd12, 4, np, 1, 0);

        // Respawn during candidate 12 restarts from (0,0) with the new type.
        fill_pattern(0);
        lat = 2;
        do_spawn(5'd9, 3'd4, base);
        for (int i = 0; i < 400; i++) begin
            #1;
            if (pulses_total - base >= 12) break;
            @(negedge clk);
        end
        check("ab_reached_12", 32'(pulses_total - base), 32'd12);
        repeat (3) @(negedge clk);
        do_spawn(5'd2, 3'd4, base);
        check("ab_plan_low", 32'(plan_valid_o), 32'd0);
        check("ab_busy", 32'(busy_o), 32'd1);
        check("ab_type", 32'(best_type_o), 32'd2);
        check("ab_cand", 32'({cand_col_o, cand_rot_o}), 32'd0);
        check("ab_start", 32'(extract_start_o), 32'd1);
        wait_done("ab", 3000, base, np);
        check_plan("ab", 5'd2, 4, np, 0, 0);

        // AI mode dropped mid-WAIT: idle next cycle, no further requests.
        lat = 20;
        do_spawn(5'd6, 3'd4, base);
        repeat (3) @(negedge clk);
        ai_en_i = 1'b0;
        @(negedge clk);
        check("en_busy", 32'(busy_o), 32'd0);
        check("en_plan", 32'(plan_valid_o), 32'd0);
        check("en_start", 32'(extract_start_o), 32'd0);
        check("en_type_held", 32'(best_type_o), 32'd6);
        #1 base = pulses_total;
        repeat (40) @(negedge clk);
        #1;
        check("en_no_pulses", 32'(pulses_total - base), 32'd0);

        // Spawn with AI mode off is ignored.
        do_spawn(5'd20, 3'd4, base);
        repeat (5) @(negedge clk);
        #1;
        check("dis_busy", 32'(busy_o), 32'd0);
        check("dis_type", 32'(best_type_o), 32'd6);
        check("dis_pulses", 32'(pulses_total - base), 32'd0);
        ai_en_i = 1'b1;
        repeat (3) @(negedge clk);
        check("reen_busy", 32'(busy_o), 32'd0);

        // Asynchronous reset mid-search.
        lat = 2;
        do_spawn(5'd7, 3'd4, base);
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_busy", 32'(busy_o), 32'd0);
        check("ar_type", 32'(best_type_o), 32'd0);
        check("ar_cand", 32'({cand_col_o, cand_rot_o}), 32'd0);
        check("ar_start", 32'(extract_start_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 base = pulses_total;
        repeat (50) @(negedge clk);
        #1;
        check("ar_no_pulses", 32'(pulses_total - base), 32'd0);
        check("ar_idle_busy", 32'(busy_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
